// File: rtl/i2s_pkg.sv
// Shared types and constants for the I2S serial audio blocks.
package i2s_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SKIP,
    SHIFT,
    WAIT
  } i2s_state_e;

  localparam int MODE_I2S = 0;
  localparam int MODE_LJ  = 1;

  localparam logic CH_LEFT  = 1'b0;
  localparam logic CH_RIGHT = 1'b1;

endpackage

// File: rtl/i2s_edge_det.sv
// Word-select edge detector: registers lrclk and flags a change, reporting the new channel.
module i2s_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic lrclk,
  output logic lr_edge,
  output logic new_ch
);

  logic prev_lr_q;
  logic prev_lr_d;

  always_comb begin
    prev_lr_d = lrclk;
  end

  // Loaded from lrclk in reset too, so leaving reset never looks like an edge.
  always_ff @(posedge clk) begin
    prev_lr_q <= prev_lr_d;
  end

  assign lr_edge = ~rst & (lrclk ^ prev_lr_q);
  assign new_ch  = lrclk;

endmodule

// File: rtl/i2s_rx_stereo.sv
// Stereo I2S / left-justified receiver: captures DATA_W bits per channel and
// reports per-channel, per-frame and framing-error pulses, all in the sclk domain.
module i2s_rx_stereo
  import i2s_pkg::*;
#(
  parameter int DATA_W = 24,
  parameter int SLOT_W = 32,
  parameter int MODE   = 0
) (
  input  logic              sclk,
  input  logic              rst,
  input  logic              lrclk,
  input  logic              sdin,
  output logic [DATA_W-1:0] l_data,
  output logic [DATA_W-1:0] r_data,
  output logic              ch_valid,
  output logic              ch_id,
  output logic              frame_valid,
  output logic              sync_err
);

  localparam int SH_W  = DATA_W - 1;
  localparam int CNT_W = $clog2(DATA_W + 1);

  if (DATA_W < 8 || DATA_W > 32 || SLOT_W < DATA_W || SLOT_W > 64) begin : g_cfg_check
    $fatal(1, "i2s_rx_stereo: illegal DATA_W/SLOT_W combination");
  end

  logic lr_edge;
  logic new_ch;

  i2s_edge_det u_edge_det (
    .clk     (sclk),
    .rst     (rst),
    .lrclk   (lrclk),
    .lr_edge (lr_edge),
    .new_ch  (new_ch)
  );

  i2s_state_e        state_q, state_d;
  logic [SH_W-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              cur_ch_q, cur_ch_d;
  logic [DATA_W-1:0] l_data_q, l_data_d;
  logic [DATA_W-1:0] r_data_q, r_data_d;
  logic              ch_valid_q, ch_valid_d;
  logic              ch_id_q, ch_id_d;
  logic              frame_valid_q, frame_valid_d;
  logic              sync_err_q, sync_err_d;
  logic              left_done_q, left_done_d;

  logic [DATA_W-1:0] word;
  logic              last_bit;
  logic              word_done;
  logic              restart;

  always_comb begin
    state_d       = state_q;
    shift_d       = shift_q;
    cnt_d         = cnt_q;
    cur_ch_d      = cur_ch_q;
    l_data_d      = l_data_q;
    r_data_d      = r_data_q;
    ch_id_d       = ch_id_q;
    left_done_d   = left_done_q;
    ch_valid_d    = 1'b0;
    frame_valid_d = 1'b0;
    sync_err_d    = 1'b0;
    word          = {shift_q, sdin};
    last_bit      = (cnt_q == CNT_W'(DATA_W - 1));
    word_done     = 1'b0;
    restart       = 1'b0;

    case (state_q)
      IDLE, WAIT: begin
        restart = lr_edge;
      end
      SKIP: begin
        if (lr_edge) begin
          restart    = 1'b1;
          sync_err_d = 1'b1;
        end else begin
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // In I2S the LSB of a full-slot word lands on the next edge cycle.
        word_done = last_bit && (!lr_edge || MODE == MODE_I2S);
        if (lr_edge) begin
          restart    = 1'b1;
          sync_err_d = ~word_done;
        end else if (word_done) begin
          state_d = WAIT;
        end else begin
          shift_d = word[SH_W-1:0];
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (word_done) begin
      ch_valid_d = 1'b1;
      ch_id_d    = cur_ch_q;
      if (cur_ch_q == CH_LEFT) begin
        l_data_d    = word;
        left_done_d = 1'b1;
      end else begin
        r_data_d      = word;
        frame_valid_d = left_done_q;
        left_done_d   = 1'b0;
      end
    end

    if (sync_err_d) begin
      left_done_d = 1'b0;
    end

    // The I2S skip slot is the edge cycle itself, so the MSB follows on the next sclk.
    if (restart) begin
      cur_ch_d = new_ch;
      state_d  = SHIFT;
      if (MODE == MODE_LJ) begin
        shift_d = SH_W'(sdin);
        cnt_d   = CNT_W'(1);
      end else begin
        shift_d = '0;
        cnt_d   = '0;
      end
    end
  end

  always_ff @(posedge sclk) begin
    if (rst) begin
      state_q       <= IDLE;
      shift_q       <= '0;
      cnt_q         <= '0;
      cur_ch_q      <= CH_LEFT;
      l_data_q      <= '0;
      r_data_q      <= '0;
      ch_valid_q    <= 1'b0;
      ch_id_q       <= 1'b0;
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
      left_done_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      shift_q       <= shift_d;
      cnt_q         <= cnt_d;
      cur_ch_q      <= cur_ch_d;
      l_data_q      <= l_data_d;
      r_data_q      <= r_data_d;
      ch_valid_q    <= ch_valid_d;
      ch_id_q       <= ch_id_d;
      frame_valid_q <= frame_valid_d;
      sync_err_q    <= sync_err_d;
      left_done_q   <= left_done_d;
    end
  end

  assign l_data      = l_data_q;
  assign r_data      = r_data_q;
  assign ch_valid    = ch_valid_q;
  assign ch_id       = ch_id_q;
  assign frame_valid = frame_valid_q;
  assign sync_err    = sync_err_q;

endmodule
